// File: rtl/idli_utx_m_if.sv
// Handshake bundle between EX and the UART transmit stage.
// The slave modport is the transmitter's view; master is the EX/driver view.
interface idli_utx_m_if;
  logic [1:0] i_utx_ctr;
  logic [3:0] i_utx_data;
  logic       i_utx_vld;
  logic       o_utx_acp;
  logic       o_utx_busy;
  logic       o_utx_data;

  modport slave (
    input  i_utx_ctr,
    input  i_utx_data,
    input  i_utx_vld,
    output o_utx_acp,
    output o_utx_busy,
    output o_utx_data
  );

  modport master (
    output i_utx_ctr,
    output i_utx_data,
    output i_utx_vld,
    input  o_utx_acp,
    input  o_utx_busy,
    input  o_utx_data
  );
endinterface

// File: rtl/idli_utx_m.sv
// UART transmit stage: gathers a 16b word as four slices aligned to the core
// slice counter, then sends it as two start/8-data/stop frames, LSB first.
module idli_utx_m #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic         i_utx_gck,
  input  logic         i_utx_rst,
  idli_utx_m_if.slave  utx
);

  localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [SW-1:0] STP_LAST = SW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   word_q,  word_d;
  logic          byte_q,  byte_d;
  logic [2:0]    bit_q,   bit_d;
  logic [SW-1:0] stp_q,   stp_d;
  logic          line_q,  line_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    stp_d   = stp_q;

    case (state_q)
      S_IDLE: begin
        if (utx.i_utx_vld && (utx.i_utx_ctr == 2'd0)) begin
          word_d[3:0] = utx.i_utx_data;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // A missing slice means EX abandoned the word; drop what was gathered.
        if (!utx.i_utx_vld) begin
          state_d = S_IDLE;
        end else begin
          word_d[4*utx.i_utx_ctr +: 4] = utx.i_utx_data;
          if (utx.i_utx_ctr == 2'd3) begin
            state_d = S_START;
            byte_d  = 1'b0;
          end
        end
      end
      S_START: begin
        state_d = S_DATA;
        bit_d   = 3'd0;
      end
      S_DATA: begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          stp_d   = '0;
        end
      end
      S_STOP: begin
        if (stp_q == STP_LAST) begin
          stp_d = '0;
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = S_START;
          end else begin
            byte_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          stp_d = stp_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so the serial output can be a
  // plain flop while the start bit still appears one cycle after the last slice.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = word_q[{byte_d, bit_d}];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_utx_gck) begin
    if (i_utx_rst) begin
      state_q <= S_IDLE;
      byte_q  <= 1'b0;
      bit_q   <= 3'd0;
      stp_q   <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      stp_q   <= stp_d;
      line_q  <= line_d;
    end
  end

  always_ff @(posedge i_utx_gck) begin
    word_q <= word_d;
  end

  assign utx.o_utx_acp  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign utx.o_utx_busy = (state_q != S_IDLE);
  assign utx.o_utx_data = line_q;

endmodule

// File: tb/tb_idli_utx_m.sv
// Bench for idli_utx_m: one instance with a single stop bit and one with three,
// checked cycle by cycle against a frame model and an RX-style decoder.
module tb_idli_utx_m;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ctr;
  int         npass = 0;
  int         nchk  = 0;

  always #5 clk = ~clk;

  idli_utx_m_if ifa ();
  idli_utx_m_if ifb ();

  idli_utx_m #(.STOP_BITS(1)) u_a (.i_utx_gck(clk), .i_utx_rst(rst), .utx(ifa));
  idli_utx_m #(.STOP_BITS(3)) u_b (.i_utx_gck(clk), .i_utx_rst(rst), .utx(ifb));

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ctr           = ctr + 2'd1;
    ifa.i_utx_ctr = ctr;
    ifb.i_utx_ctr = ctr;
  endtask

  task automatic set_in(input bit va, input bit vb, input logic [3:0] d);
    ifa.i_utx_vld  = va;
    ifb.i_utx_vld  = vb;
    ifa.i_utx_data = va ? d : 4'($urandom);
    ifb.i_utx_data = vb ? d : 4'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_line_a"}, ifa.o_utx_data, 1'b1);
    chk({tag, "_acp_a"},  ifa.o_utx_acp,  1'b1);
    chk({tag, "_busy_a"}, ifa.o_utx_busy, 1'b0);
    chk({tag, "_line_b"}, ifb.o_utx_data, 1'b1);
    chk({tag, "_acp_b"},  ifb.o_utx_acp,  1'b1);
    chk({tag, "_busy_b"}, ifb.o_utx_busy, 1'b0);
  endtask

  // Frame model: k counts cycles from the start bit of byte 0.
  function automatic logic exp_line(input logic [15:0] w, input int sb, input int k);
    int fl = 9 + sb;
    int p;
    if (k >= 2 * fl) return 1'b1;
    p = k % fl;
    if (p == 0) return 1'b0;
    if (p <= 8) return w[8 * (k / fl) + p - 1];
    return 1'b1;
  endfunction

  // Receiver model: hunt for a low start bit, take eight bits after it.
  function automatic logic [15:0] rx_word(input logic c [0:31], input int n);
    logic [15:0] w = '0;
    int idx = 0;
    for (int b = 0; b < 2; b++) begin
      while (idx < n && c[idx] == 1'b1) idx++;
      for (int i = 0; i < 8; i++)
        w[8 * b + i] = (idx + 1 + i < n) ? c[idx + 1 + i] : 1'b0;
      idx += 10;
    end
    return w;
  endfunction

  task automatic wait_start(input bit ua, input bit ub);
    int n = 0;
    while (!(ctr == 2'd0 && (!ua || ifa.o_utx_acp) && (!ub || ifb.o_utx_acp)) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_start_bound", (n < 200), 1'b1);
  endtask

  task automatic send_word(input logic [15:0] w, input bit ua, input bit ub, input int abort_k);
    logic ca [0:31];
    logic cb [0:31];
    int la = 2 * (9 + 1);
    int lb = 2 * (9 + 3);
    int kmax;
    for (int i = 0; i < 32; i++) begin
      ca[i] = 1'b1;
      cb[i] = 1'b1;
    end
    wait_start(ua, ub);
    for (int i = 0; i < 4; i++) begin
      if (ua) begin
        chk("load_acp_a",  ifa.o_utx_acp,  1'b1);
        chk("load_busy_a", ifa.o_utx_busy, (i != 0));
        chk("load_line_a", ifa.o_utx_data, 1'b1);
      end
      if (ub) begin
        chk("load_acp_b",  ifb.o_utx_acp,  1'b1);
        chk("load_busy_b", ifb.o_utx_busy, (i != 0));
        chk("load_line_b", ifb.o_utx_data, 1'b1);
      end
      set_in(ua, ub, w[4*i +: 4]);
      tick();
    end
    set_in(1'b0, 1'b0, 4'h0);
    kmax = ub ? lb : la;
    for (int k = 0; k <= kmax; k++) begin
      if (ua) begin
        ca[k] = ifa.o_utx_data;
        chk("line_a", ifa.o_utx_data, exp_line(w, 1, k));
        chk("acp_a",  ifa.o_utx_acp,  (k >= la));
        chk("busy_a", ifa.o_utx_busy, (k < la));
      end
      if (ub) begin
        cb[k] = ifb.o_utx_data;
        chk("line_b", ifb.o_utx_data, exp_line(w, 3, k));
        chk("acp_b",  ifb.o_utx_acp,  (k >= lb));
        chk("busy_b", ifb.o_utx_busy, (k < lb));
      end
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort");
        return;
      end
      if (k < kmax) tick();
    end
    if (ua) chk("rx_a", rx_word(ca, kmax + 1), w);
    if (ub) chk("rx_b", rx_word(cb, kmax + 1), w);
  endtask

  initial begin
    logic [15:0] w;
    bit ua, ub;
    rst = 1'b1;
    ctr = 2'd0;
    ifa.i_utx_ctr = ctr;
    ifb.i_utx_ctr = ctr;
    set_in(1'b0, 1'b0, 4'h0);
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // Basic word on both stop-bit settings.
    send_word(16'hA55A, 1'b1, 1'b1, -1);

    // A slice offered at ctr==2 while idle must be ignored.
    for (int n = 0; n < 4 && ctr != 2'd2; n++) tick();
    set_in(1'b1, 1'b1, 4'($urandom));
    tick();
    set_in(1'b0, 1'b0, 4'h0);
    for (int n = 0; n < 3; n++) begin
      chk_idle("ignored");
      tick();
    end
    send_word(16'h5A3C, 1'b1, 1'b1, -1);

    // vld dropping mid-load discards the partial word.
    wait_start(1'b1, 1'b1);
    set_in(1'b1, 1'b1, 4'h7);
    tick();
    set_in(1'b1, 1'b1, 4'h8);
    tick();
    set_in(1'b0, 1'b0, 4'h0);
    chk("drop_busy_a", ifa.o_utx_busy, 1'b1);
    chk("drop_busy_b", ifb.o_utx_busy, 1'b1);
    tick();
    for (int n = 0; n < 3; n++) begin
      chk_idle("dropped");
      tick();
    end
    send_word(16'h0001, 1'b1, 1'b1, -1);

    // Reset during byte 1 data bit 4 of the single-stop-bit instance.
    send_word(16'h1357, 1'b1, 1'b1, 15);
    send_word(16'hFFFF, 1'b1, 1'b1, -1);

    // Back-to-back words at the earliest opportunity.
    send_word(16'h1234, 1'b1, 1'b0, -1);
    send_word(16'hFEDC, 1'b1, 1'b0, -1);

    // Three stop bits on their own.
    send_word(16'h00FF, 1'b0, 1'b1, -1);
    send_word(16'h8001, 1'b0, 1'b1, -1);

    // Random words, instance mix and idle gaps.
    for (int r = 0; r < 14; r++) begin
      w  = 16'($urandom);
      ua = 1'($urandom);
      ub = 1'($urandom);
      if (!ua && !ub) ua = 1'b1;
      for (int g = 0; g < int'($urandom_range(0, 5)); g++) tick();
      send_word(w, ua, ub, -1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
